// File: rtl/turret_motion_ctrl.sv
// APB3 turret actuator scheduler: slew-limited pan/tilt servo PWM, frame-aligned IR
// fire sequence and a synchronised hit latch that raises FABINT.
module turret_motion_ctrl #(
    parameter int PERIOD_CYCLES = 2000000,
    parameter int WIDTH_MIN     = 100000,
    parameter int WIDTH_MAX     = 200000,
    parameter int IR_HALF       = 1316,
    parameter int FIRE_FRAMES   = 5,
    parameter int COOL_FRAMES   = 50
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        hit_data,
    output logic        pwm_out1,
    output logic        pwm_out2,
    output logic        pwm_out_IR,
    output logic        FABINT
);

    localparam int CW   = $clog2(PERIOD_CYCLES);
    localparam int FMAX = (FIRE_FRAMES > COOL_FRAMES) ? FIRE_FRAMES : COOL_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);
    localparam int IW   = $clog2(IR_HALF + 1);
    localparam logic [20:0] CENTER   = 21'((WIDTH_MIN + WIDTH_MAX) / 2);
    localparam logic [20:0] STEP_RST = 21'd1000;

    typedef enum logic [1:0] {IDLE, ARM, BURST, COOL} fire_state_t;

    logic [CW-1:0] cnt;
    logic          frame_tick;
    logic [20:0]   target1, target2, cur1, cur2, step;
    logic          irq_en, hit;
    logic          sync1, sync2, sync3, hit_edge;
    logic          wr_en, fire_req, hit_clr;
    logic [2:0]    reg_idx;
    logic          busy, moving1, moving2;

    fire_state_t   state, state_next;
    logic [FW-1:0] frames, frames_next;
    logic [IW-1:0] ir_cnt, ir_cnt_next;
    logic          ir, ir_next;

    logic          unused_addr;

    assign unused_addr = ^{PADDR[31:5], PADDR[1:0]};
    assign reg_idx     = PADDR[4:2];
    assign wr_en       = PSEL & PENABLE & PWRITE;
    assign fire_req    = wr_en && (reg_idx == 3'd3) && PWDATA[0];
    assign hit_clr     = wr_en && (reg_idx == 3'd4) && PWDATA[1];
    assign hit_edge    = sync2 & ~sync3;
    assign frame_tick  = (cnt == CW'(PERIOD_CYCLES - 1));
    assign busy        = (state != IDLE);
    assign moving1     = (cur1 != target1);
    assign moving2     = (cur2 != target2);
    assign PREADY      = 1'b1;
    assign PSLVERR     = 1'b0;
    assign pwm_out_IR  = ir;

    function automatic logic [20:0] clamp_width(input logic [31:0] v);
        if (v < 32'(WIDTH_MIN))
            return 21'(WIDTH_MIN);
        else if (v > 32'(WIDTH_MAX))
            return 21'(WIDTH_MAX);
        else
            return v[20:0];
    endfunction

    // Move at most one step toward the target without overshooting it.
    function automatic logic [20:0] slew(input logic [20:0] cur, input logic [20:0] tgt,
                                         input logic [20:0] stp);
        logic [20:0] diff;
        logic [20:0] delta;
        diff  = (tgt > cur) ? (tgt - cur) : (cur - tgt);
        delta = (stp < diff) ? stp : diff;
        return (tgt > cur) ? (cur + delta) : (cur - delta);
    endfunction

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt      <= '0;
            pwm_out1 <= 1'b0;
            pwm_out2 <= 1'b0;
        end else begin
            cnt      <= frame_tick ? '0 : cnt + 1'b1;
            pwm_out1 <= (32'(cnt) < 32'(cur1));
            pwm_out2 <= (32'(cnt) < 32'(cur2));
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            target1 <= CENTER;
            target2 <= CENTER;
            cur1    <= CENTER;
            cur2    <= CENTER;
            step    <= STEP_RST;
            irq_en  <= 1'b0;
        end else begin
            if (frame_tick) begin
                cur1 <= slew(cur1, target1, step);
                cur2 <= slew(cur2, target2, step);
            end
            if (wr_en) begin
                case (reg_idx)
                    3'd0:    target1 <= clamp_width(PWDATA);
                    3'd1:    target2 <= clamp_width(PWDATA);
                    3'd2:    step    <= PWDATA[20:0];
                    3'd3:    irq_en  <= PWDATA[1];
                    default: ;
                endcase
            end
        end
    end

    // A fresh hit edge wins over a simultaneous clear so no event is lost.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync3  <= 1'b0;
            hit    <= 1'b0;
            FABINT <= 1'b0;
        end else begin
            sync1  <= hit_data;
            sync2  <= sync1;
            sync3  <= sync2;
            if (hit_edge)
                hit <= 1'b1;
            else if (hit_clr)
                hit <= 1'b0;
            FABINT <= hit & irq_en;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state  <= IDLE;
            frames <= '0;
            ir_cnt <= '0;
            ir     <= 1'b0;
        end else begin
            state  <= state_next;
            frames <= frames_next;
            ir_cnt <= ir_cnt_next;
            ir     <= ir_next;
        end
    end

    always_comb begin
        state_next  = state;
        frames_next = frames;
        ir_cnt_next = ir_cnt;
        ir_next     = ir;
        case (state)
            IDLE: begin
                ir_next = 1'b0;
                if (fire_req)
                    state_next = ARM;
            end
            ARM: begin
                ir_next = 1'b0;
                if (frame_tick) begin
                    state_next  = BURST;
                    frames_next = '0;
                    ir_cnt_next = '0;
                    ir_next     = 1'b1;
                end
            end
            BURST: begin
                if (ir_cnt == IW'(IR_HALF - 1)) begin
                    ir_cnt_next = '0;
                    ir_next     = ~ir;
                end else begin
                    ir_cnt_next = ir_cnt + 1'b1;
                end
                if (frame_tick) begin
                    if (frames == FW'(FIRE_FRAMES - 1)) begin
                        state_next  = COOL;
                        frames_next = '0;
                        ir_next     = 1'b0;
                    end else begin
                        frames_next = frames + 1'b1;
                    end
                end
            end
            COOL: begin
                ir_next = 1'b0;
                if (frame_tick) begin
                    if (frames == FW'(COOL_FRAMES - 1)) begin
                        state_next  = IDLE;
                        frames_next = '0;
                    end else begin
                        frames_next = frames + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (reg_idx)
                3'd0:    PRDATA = {11'd0, target1};
                3'd1:    PRDATA = {11'd0, target2};
                3'd2:    PRDATA = {11'd0, step};
                3'd3:    PRDATA = {30'd0, irq_en, 1'b0};
                3'd4:    PRDATA = {28'd0, moving2, moving1, hit, busy};
                3'd5:    PRDATA = {11'd0, cur1};
                3'd6:    PRDATA = {11'd0, cur2};
                default: PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_turret_motion_ctrl.sv
// Self-checking bench for turret_motion_ctrl: directed scenarios with literal expectations
// plus randomized APB/hit traffic, all compared every cycle against a behavioural model.
module tb_turret_motion_ctrl;

    localparam int P    = 100;
    localparam int WMIN = 10;
    localparam int WMAX = 50;
    localparam int IH   = 2;
    localparam int FF   = 2;
    localparam int CF   = 3;

    logic        PCLK = 1'b0;
    logic        PRESET, PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR, hit_data;
    logic        pwm_out1, pwm_out2, pwm_out_IR, FABINT;

    int checks = 0;
    int errors = 0;

    turret_motion_ctrl #(
        .PERIOD_CYCLES(P), .WIDTH_MIN(WMIN), .WIDTH_MAX(WMAX),
        .IR_HALF(IH), .FIRE_FRAMES(FF), .COOL_FRAMES(CF)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .hit_data(hit_data), .pwm_out1(pwm_out1), .pwm_out2(pwm_out2),
        .pwm_out_IR(pwm_out_IR), .FABINT(FABINT)
    );

    always #5 PCLK = ~PCLK;

    // Model state describes the cycle numbered m_now since the last reset edge.
    bit m_valid = 1'b0;
    int m_now, m_tgt1, m_tgt2, m_cur1, m_cur2, m_step;
    bit m_irq, m_hit, hd1, hd2, hd3;
    int m_fire_acc, m_t0, m_end;
    bit exp_pwm1, exp_pwm2, exp_fab;

    function automatic int approach(input int c, input int t, input int s);
        int d;
        int m;
        d = (t > c) ? t - c : c - t;
        m = (s < d) ? s : d;
        return (t > c) ? c + m : c - m;
    endfunction

    function automatic int clamp(input logic [31:0] v);
        if (v < 32'(WMIN)) return WMIN;
        if (v > 32'(WMAX)) return WMAX;
        return int'(v);
    endfunction

    function automatic bit m_busy(input int x);
        return (x > m_fire_acc) && (x <= m_end);
    endfunction

    function automatic bit m_ir(input int x);
        return (x > m_t0) && (x <= m_t0 + FF * P) && ((((x - m_t0 - 1) / IH) % 2) == 0);
    endfunction

    function automatic logic [31:0] m_prdata();
        if (!(PSEL && !PWRITE)) return 32'd0;
        case (PADDR[4:2])
            3'd0: return 32'(m_tgt1);
            3'd1: return 32'(m_tgt2);
            3'd2: return 32'(m_step);
            3'd3: return {30'd0, m_irq, 1'b0};
            3'd4: return {28'd0, m_cur2 != m_tgt2, m_cur1 != m_tgt1, m_hit, m_busy(m_now)};
            3'd5: return 32'(m_cur1);
            3'd6: return 32'(m_cur2);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge PCLK) begin
        if (PRESET) begin
            m_valid = 1'b1;
            m_now = 0;
            m_tgt1 = (WMIN + WMAX) / 2; m_tgt2 = m_tgt1; m_cur1 = m_tgt1; m_cur2 = m_tgt1;
            m_step = 1000; m_irq = 0; m_hit = 0; hd1 = 0; hd2 = 0; hd3 = 0;
            m_fire_acc = -1; m_end = -1; m_t0 = -10 * P;
            exp_pwm1 = 0; exp_pwm2 = 0; exp_fab = 0;
        end else if (m_valid) begin
            int  c;
            bit  wr;
            bit  hedge;
            c     = m_now % P;
            wr    = PSEL && PENABLE && PWRITE;
            hedge = hd2 && !hd3;
            exp_pwm1 = (c < m_cur1);
            exp_pwm2 = (c < m_cur2);
            exp_fab  = m_hit && m_irq;
            if (c == P - 1) begin
                m_cur1 = approach(m_cur1, m_tgt1, m_step);
                m_cur2 = approach(m_cur2, m_tgt2, m_step);
            end
            if (wr) begin
                case (PADDR[4:2])
                    3'd0: m_tgt1 = clamp(PWDATA);
                    3'd1: m_tgt2 = clamp(PWDATA);
                    3'd2: m_step = int'(PWDATA[20:0]);
                    3'd3: begin
                        m_irq = PWDATA[1];
                        if (PWDATA[0] && !m_busy(m_now)) begin
                            m_fire_acc = m_now;
                            m_t0 = m_now - c + P - 1;
                            if (m_t0 == m_now) m_t0 += P;
                            m_end = m_t0 + (FF + CF) * P;
                        end
                    end
                    default: ;
                endcase
            end
            if (hedge) m_hit = 1;
            else if (wr && PADDR[4:2] == 3'd4 && PWDATA[1]) m_hit = 0;
            hd3 = hd2; hd2 = hd1; hd1 = hit_data;
            m_now++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge PCLK) begin
        if (m_valid) begin
            checkOutput("pwm_out1", 32'(pwm_out1), 32'(exp_pwm1));
            checkOutput("pwm_out2", 32'(pwm_out2), 32'(exp_pwm2));
            checkOutput("pwm_out_IR", 32'(pwm_out_IR), 32'(m_ir(m_now)));
            checkOutput("FABINT", 32'(FABINT), 32'(exp_fab));
            checkOutput("PREADY", 32'(PREADY), 32'd1);
            checkOutput("PSLVERR", 32'(PSLVERR), 32'd0);
            checkOutput("PRDATA", PRDATA, m_prdata());
        end
    end

    // One APB transfer starting in the current cycle; noise fills the ignored address bits.
    task automatic applyStimulus(input bit wr, input logic [2:0] idx, input logic [31:0] data,
                                 input logic [31:0] noise, output logic [31:0] rdata);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
        PADDR = {noise[31:5], idx, noise[1:0]};
        PWDATA = data;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        rdata = PRDATA;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apbWrite(input logic [2:0] idx, input logic [31:0] data);
        logic [31:0] dummy;
        applyStimulus(1'b1, idx, data, 32'd0, dummy);
    endtask

    task automatic apbRead(input logic [2:0] idx, output logic [31:0] rdata);
        applyStimulus(1'b0, idx, 32'd0, 32'd0, rdata);
    endtask

    task automatic waitCount(input int v);
        int n = 0;
        while ((m_now % P) != v && n < 2 * P) begin
            @(posedge PCLK); #1;
            n++;
        end
        if (n >= 2 * P) begin
            checks++; errors++;
            $display("[TB] FAIL wait_count: got timeout expected cnt=%0d", v);
        end
    endtask

    task automatic nextCycle(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] noise;
        int exp_cur[5] = '{34, 38, 42, 45, 45};
        int cnt1, cnt2, irc, lat;
        logic first_ir;

        PRESET = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; hit_data = 0;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;

        $display("[TB] reset values");
        checkOutput("rst_pwm1", 32'(pwm_out1), 32'd0);
        checkOutput("rst_ir", 32'(pwm_out_IR), 32'd0);
        checkOutput("rst_fabint", 32'(FABINT), 32'd0);
        apbRead(3'd2, rd); checkOutput("rst_step", rd, 32'd1000);
        apbRead(3'd0, rd); checkOutput("rst_target1", rd, 32'd30);

        $display("[TB] centred pulse width");
        nextCycle(300);
        cnt1 = 0; cnt2 = 0;
        for (int i = 0; i < P; i++) begin
            @(negedge PCLK);
            cnt1 += int'(pwm_out1); cnt2 += int'(pwm_out2);
        end
        nextCycle(1);
        checkOutput("pwm1_high_count", 32'(cnt1), 32'd30);
        checkOutput("pwm2_high_count", 32'(cnt2), 32'd30);
        checkOutput("pready_const", 32'(PREADY), 32'd1);
        checkOutput("pslverr_const", 32'(PSLVERR), 32'd0);
        apbRead(3'd5, rd); checkOutput("cur1_center", rd, 32'd30);

        $display("[TB] slew toward target");
        waitCount(50);
        apbWrite(3'd2, 32'd4);
        apbWrite(3'd0, 32'd45);
        for (int i = 0; i < 5; i++) begin
            waitCount(10);
            apbRead(3'd5, rd);
            checkOutput($sformatf("cur1_step%0d", i), rd, 32'(exp_cur[i]));
        end
        apbRead(3'd4, rd); checkOutput("moving1_clear", 32'(rd[2]), 32'd0);

        $display("[TB] target clamping");
        apbWrite(3'd1, 32'd5);   apbRead(3'd1, rd); checkOutput("target2_clamp_low", rd, 32'd10);
        apbWrite(3'd1, 32'd999); apbRead(3'd1, rd); checkOutput("target2_clamp_high", rd, 32'd50);

        $display("[TB] fire sequence");
        waitCount(50);
        apbWrite(3'd3, 32'd1);
        waitCount(0);
        irc = 0;
        for (int i = 0; i < FF * P; i++) begin
            @(negedge PCLK);
            if (i == 0) first_ir = pwm_out_IR;
            irc += int'(pwm_out_IR);
        end
        @(negedge PCLK);
        checkOutput("ir_after_burst", 32'(pwm_out_IR), 32'd0);
        nextCycle(1);
        checkOutput("ir_first_level", 32'(first_ir), 32'd1);
        checkOutput("ir_high_count", 32'(irc), 32'd100);
        apbRead(3'd4, rd); checkOutput("busy_in_cool", 32'(rd[0]), 32'd1);
        apbWrite(3'd3, 32'd1);
        nextCycle(310);
        apbRead(3'd4, rd); checkOutput("fire_in_cool_ignored", 32'(rd[0]), 32'd0);

        $display("[TB] hit interrupt");
        apbWrite(3'd3, 32'd2);
        hit_data = 1'b1;
        lat = 0;
        while (lat < 6 && !FABINT) begin
            nextCycle(1);
            lat++;
        end
        checkOutput("fabint_within_4", 32'(lat <= 4 && FABINT), 32'd1);
        hit_data = 1'b0;
        nextCycle(6);
        hit_data = 1'b1;
        nextCycle(1);
        apbWrite(3'd4, 32'd2);
        apbRead(3'd4, rd); checkOutput("hit_edge_beats_w1c", 32'(rd[1]), 32'd1);
        checkOutput("fabint_held", 32'(FABINT), 32'd1);
        apbWrite(3'd4, 32'd2);
        nextCycle(2);
        checkOutput("fabint_after_w1c", 32'(FABINT), 32'd0);
        hit_data = 1'b0;
        nextCycle(6);

        $display("[TB] reset during burst");
        waitCount(50);
        apbWrite(3'd2, 32'd3);
        apbWrite(3'd0, 32'd10);
        apbWrite(3'd3, 32'd1);
        waitCount(20);
        apbRead(3'd5, rd); checkOutput("cur1_pre_reset", rd, 32'd42);
        waitCount(40);
        checkOutput("ir_pre_reset", 32'(pwm_out_IR), 32'd1);
        PRESET = 1'b1;
        nextCycle(1);
        PRESET = 1'b0;
        checkOutput("ir_post_reset", 32'(pwm_out_IR), 32'd0);
        apbRead(3'd4, rd); checkOutput("status_post_reset", rd, 32'd0);
        apbRead(3'd5, rd); checkOutput("cur1_post_reset", rd, 32'd30);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 400; it++) begin
            logic [2:0]  idx;
            logic [31:0] data;
            int          op;
            if ($urandom_range(0, 3) == 0) hit_data = ~hit_data;
            noise = $urandom();
            idx   = 3'($urandom_range(0, 7));
            case (idx)
                3'd0, 3'd1: data = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 70));
                3'd2:       data = 32'($urandom_range(0, 8));
                default:    data = $urandom();
            endcase
            op = $urandom_range(0, 3);
            if (it == 200) begin
                PRESET = 1'b1;
                nextCycle(1);
                PRESET = 1'b0;
            end else if (op == 0 || op == 1) begin
                applyStimulus(op == 0, idx, data, noise, rd);
            end else if (op == 2) begin
                nextCycle($urandom_range(1, 20));
            end else begin
                applyStimulus(1'b1, 3'd3, {30'd0, 1'($urandom_range(0, 1)), 1'b1}, noise, rd);
            end
        end
        nextCycle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
